// File: rtl/shift_and_subtract_binary_divider.sv
// ---------------------------------------------------------------------------
// shift_and_subtract_binary_divider
//
// Sequential restoring divider for unsigned operands. It computes Q = A / B
// and R = A % B, one quotient bit per clock, MSB first. It is the inverse
// datapath of the shift-and-add multiplier.
//
// Handshake
//   start is sampled only in IDLE or DONE. A normal division takes m cycles
//   after the accepting edge. A divide by zero finishes on the accepting edge
//   itself. A start held high in the DONE cycle is accepted, so back-to-back
//   operations give one result every m+1 cycles.
//
// Parameters
//   m : dividend / quotient width (m >= n >= 2)
//   n : divisor / remainder width
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, priority over start
//   start        in   operation request
//   A [m-1:0]    in   dividend, latched on the accepted start edge
//   B [n-1:0]    in   divisor, latched on the accepted start edge
//   Q [m-1:0]    out  quotient, registered, updated only with done
//   R [n-1:0]    out  remainder, registered, updated only with done
//   busy         out  high while an iteration sequence is running
//   done         out  one-cycle pulse when Q/R are updated
//   div_by_zero  out  set with done for B==0, held until the next accepted start
//
// Optional build macro
//   DIV_EARLY_EXIT_EN : when defined, a start with B != 0 and A < B skips the
//                       iterations. It returns Q=0 and R=A on the accepting edge.
// ---------------------------------------------------------------------------
module shift_and_subtract_binary_divider #(
    parameter int m = 16,
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] A,
    input  logic [n-1:0] B,
    output logic [m-1:0] Q,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(m) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [m-1:0]    dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [n-1:0]    dvs_q, dvs_d;     // latched divisor
    logic [n-1:0]    rem_q, rem_d;     // partial remainder, always < divisor
    logic [CW-1:0]   cnt_q, cnt_d;     // iteration counter
    logic [m-1:0]    q_q, q_d;
    logic [n-1:0]    r_q, r_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    // ---------------------------------------------------------------------
    // One restoring iteration.
    // The stored remainder is kept below the divisor, so it fits in n bits.
    // The shifted value needs n+1 bits. Subtracting the divisor from that
    // (n+1)-bit value cannot overflow. Because shifted < 2*divisor, the MSB
    // of the difference is exactly the borrow, so it doubles as the
    // "rem >= divisor" compare.
    // ---------------------------------------------------------------------
    logic [n:0]      rem_shift;
    logic [n:0]      rem_sub;
    logic            q_bit;
    logic [n-1:0]    rem_iter;
    logic [m-1:0]    dvd_iter;

    always_comb begin
        rem_shift = {rem_q, dvd_q[m-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_sub[n];
        rem_iter  = q_bit ? rem_sub[n-1:0] : rem_shift[n-1:0];
        dvd_iter  = {dvd_q[m-2:0], q_bit};
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;          // done is a single-cycle pulse
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d = A;
                    dvs_d = B;
                    rem_d = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (B == '0) begin
                        // Divide by zero completes on the accepting edge.
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = '0;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (A < m'(B)) begin
                        // The quotient is zero, so the remainder is A itself.
                        state_d = S_DONE;
                        q_d     = '0;
                        r_d     = A[n-1:0];
                        done_d  = 1'b1;
                    end
`endif
                    else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                rem_d = rem_iter;
                dvd_d = dvd_iter;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(m - 1)) begin
                    // The last iteration's result goes straight to the outputs.
                    // Done therefore lands exactly m edges after the start edge.
                    q_d     = dvd_iter;
                    r_d     = rem_iter;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
module tb_shift_and_subtract_binary_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [7:0]  B;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    shift_and_subtract_binary_divider #(.m(16), .n(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One complete operation from IDLE, with all result checks.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edbz, input int elat);
        int c;
        launch(a, b);
        wait_done(0, c);
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, c, elat);
        check({tag, "_q"}, Q, eq);
        check({tag, "_r"}, R, er);
        check({tag, "_dbz"}, div_by_zero, edbz);
        check({tag, "_busy"}, busy, 0);
        $display("op %s: A=%0d B=%0d -> Q=%0d R=%0d dbz=%0d lat=%0d", tag, a, b, Q, R, div_by_zero, c);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ra, rb;
        logic seen_done;

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        $display("reset: Q=%0d R=%0d busy=%0d done=%0d dbz=%0d", Q, R, busy, done, div_by_zero);
        @(negedge clk);
        rst = 1'b0;

        run_op("t100_7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 16);

        // The outputs must hold the previous result while the next run is in flight.
        launch(16'd65535, 8'd255);
        repeat (3) @(posedge clk);
        #1;
        check("hold_busy", busy, 1);
        check("hold_q", Q, 14);
        check("hold_r", R, 2);
        wait_done(3, c);
        check("t65535_255_done", done, 1);
        check("t65535_255_lat", c, 16);
        check("t65535_255_q", Q, 257);
        check("t65535_255_r", R, 0);
        $display("op t65535_255: Q=%0d R=%0d lat=%0d", Q, R, c);
        @(posedge clk);
        #1;

        run_op("t65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16);

        run_op("t1234_0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 0);
        check("dbz_held", div_by_zero, 1);
        run_op("t9_3", 16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 16);

        // A second start while busy must be ignored.
        launch(16'd500, 8'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        A = 16'd10;
        B = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", busy, 1);
        wait_done(6, c);
        check("ign_done", done, 1);
        check("ign_lat", c, 16);
        check("ign_q", Q, 166);
        check("ign_r", R, 2);
        $display("op ignored-restart: Q=%0d R=%0d lat=%0d", Q, R, c);

        // A start held high in the DONE cycle is accepted.
        A = 16'd9;
        B = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        check("b2b_q_hold", Q, 166);
        wait_done(0, c);
        check("b2b_done", done, 1);
        check("b2b_lat", c, 16);
        check("b2b_q", Q, 3);
        check("b2b_r", R, 0);
        $display("op back-to-back: Q=%0d R=%0d lat=%0d", Q, R, c);
        @(posedge clk);
        #1;

        // A reset in the middle of a run aborts the run without a done pulse.
        launch(16'd200, 8'd9);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_q", Q, 0);
        check("abort_r", R, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        $display("op abort: Q=%0d R=%0d busy=%0d seen_done=%0d", Q, R, busy, seen_done);
        run_op("t200_9", 16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 16);

        run_op("t5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, EARLY ? 0 : 16);

        for (int k = 0; k < 500; k++) begin
            ra = int'($urandom_range(0, 65535));
            rb = int'($urandom_range(1, 255));
            run_op("rnd", 16'(ra), 8'(rb), 16'(ra / rb), 8'(ra % rb), 1'b0,
                   (EARLY && ra < rb) ? 0 : 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_and_subtract_binary_divider.md
Name: shift_and_subtract_binary_divider

Overview:
- Sequential restoring binary divider: the inverse datapath of the shift-and-add multiplier.
- Computes Q = A / B and R = A % B for unsigned operands, one quotient bit per clock, MSB first.
- Sits beside the multiplier in the arithmetic block set.
- Uses a start/busy/done handshake so a controller can issue operations back to back.

Parameters:
- m, 16, dividend and quotient width (m >= n >= 2)
- n, 8, divisor and remainder width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the FSM is in IDLE or DONE
- A  input  m  dividend; latched on the accepted start edge
- B  input  n  divisor; latched on the accepted start edge
- Q  output  m  quotient (reg)
- R  output  n  remainder (reg)
- busy  output  1  high while the FSM is in RUN
- done  output  1  one-cycle pulse when Q/R are updated
- div_by_zero  output  1  set with done when latched B==0; held until the next accepted start

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - Q=0, R=0, busy=0, done=0, div_by_zero=0, FSM=IDLE.
  - Internal registers (shift, partial remainder, counter) are cleared.
  - Reset during RUN aborts the operation; no done is produced.
  - rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - Latch A into the dividend shift register and B into the divisor register.
  - Clear the partial remainder (n+1 bits) and set the counter to 0.
  - If B != 0: go to RUN, busy=1.
  - If B == 0: go to DONE. Q=all ones, R=0, div_by_zero=1, done=1 on the next edge (latency 1).
- IDLE/DONE, start=0: go to or stay in IDLE; done=0.
- RUN, each edge, for iteration i = 0..m-1:
  - rem = {rem[n-1:0], dividend MSB}; shift the dividend left by 1.
  - If rem >= {1'b0,B}: rem = rem - B and the shifted-in quotient bit is 1; otherwise 0.
  - Quotient bits fill the vacated LSBs of the dividend register.
- RUN, after m iterations:
  - Q <= quotient register, R <= rem[n-1:0], done=1, busy=0, div_by_zero=0, go to DONE.
- Latency: start accepted at edge k → done high after edge k+m (m cycles).
  - done is exactly one cycle wide.
- Q/R are unchanged during RUN; they update only with done.
- start while busy=1 is ignored; A/B changes during RUN have no effect.
- start=1 in the DONE cycle is accepted; back-to-back throughput is one result per m+1 cycles.
- Arithmetic:
  - The partial remainder is n+1 bits wide so the compare never overflows.
  - The final remainder always satisfies R < B.
  - Invariant: A == Q*B + R whenever B != 0.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN
- Defined:
  - On an accepted start with B != 0 and A < B (A zero-extended), skip RUN and go straight to DONE.
  - Result: Q=0, R=A[n-1:0], done after 1 cycle.
  - All other cases are unchanged.
- Undefined:
  - A < B runs the full m iterations, giving the same Q=0, R=A after m cycles.

Test Plan:
- Reset, then A=100, B=7, start pulse → done exactly 16 cycles later; Q=14, R=2, div_by_zero=0, busy low in the done cycle.
- A=65535, B=255 → Q=257, R=0. A=65535, B=1 → Q=65535, R=0. Also a random sweep of 500 pairs checking A==Q*B+R and R<B.
- A=1234, B=0 → done after 1 cycle; Q=16'hFFFF, R=0, div_by_zero=1. A following start with A=9, B=3 clears div_by_zero: Q=3, R=0.
- Start A=500, B=3; re-pulse start with A=10, B=5 at cycle 5 while busy → ignored; done at cycle 16 with Q=166, R=2. Then a start held high in the done cycle launches the next operation.
- Start A=200, B=9; assert rst at cycle 8 → Q=0, R=0, busy=0, no done pulse; a new start after reset with A=200, B=9 gives Q=22, R=2.
- A=5, B=9 → Q=0, R=5. Done arrives after 16 cycles without DIV_EARLY_EXIT_EN and after 1 cycle with it.
